// File: rtl/spi_slave_pkg.sv
// Shared definitions for the parametrised SPI slave: FSM states, command
// codes and the command field width.
package spi_slave_pkg;

    localparam int CMD_W = 2;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT,
        HOLD
    } state_t;

    // Both read commands share their leading bit, so the first command bit
    // alone selects between the write and read paths.
    function automatic logic cmd_is_read(input logic first_bit);
        return first_bit == CMD_RD_ADDR[CMD_W-1];
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Loadable down-counter that saturates at zero; used to count frame bits on
// both the receive and the transmit side.
module spi_bit_counter #(
    parameter int WIDTH    = 4,
    parameter int LOAD_VAL = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);

    localparam logic [WIDTH-1:0] LOAD_V = WIDTH'(LOAD_VAL);

    // Load takes priority; otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_V;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises command+payload frames from MOSI for the
// RAM wrapper and serialises RAM read data back on MISO.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [DATA_W+1:0]   rx_data,
    output logic                rx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic                frame_err,
    output logic                done
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    state_t state_reg, state_next;
    logic   rd_addr_seen_reg;

    logic [CNT_W-1:0]  rx_cnt, tx_cnt;
    logic              rx_zero, tx_zero;
    logic [DATA_W-1:0] tx_buf_reg;
    logic [DATA_W-1:0] tx_shift_w;
    logic [CNT_W-1:0]  tx_idx;
    logic [CNT_W-1:0]  wr_idx;
    logic [FRAME_W-1:0] rx_data_next;

    logic rx_load, cap_en, rx_dec, tx_load, tx_dec, rd_set, rd_clr;
    logic rx_valid_next, frame_err_next, done_next, miso_next;

    // rx counter: loaded with DATA_W on frame start, one step per captured bit
    // after the first command bit; reaching zero marks the last frame bit.
    spi_bit_counter #(.WIDTH(CNT_W), .LOAD_VAL(DATA_W)) u_rx_cnt (
        .clk  (clk),
        .rstn (rstn),
        .load (rx_load),
        .en   (rx_dec),
        .cnt  (rx_cnt),
        .zero (rx_zero)
    );

    // tx counter: bits still to be driven after the first MISO bit.
    spi_bit_counter #(.WIDTH(CNT_W), .LOAD_VAL(DATA_W-1)) u_tx_cnt (
        .clk  (clk),
        .rstn (rstn),
        .load (tx_load),
        .en   (tx_dec),
        .cnt  (tx_cnt),
        .zero (tx_zero)
    );

    // Bit of the buffered read word to put on MISO for the current count.
    assign tx_idx     = MSB_FIRST ? (tx_cnt - CNT_W'(1)) : (CNT_W'(DATA_W) - tx_cnt);
    assign tx_shift_w = tx_buf_reg >> tx_idx;

    // Destination of the bit sampled this edge: command bits first, then the
    // payload from the top or bottom depending on bit order.
    always_comb begin
        if (state_reg == CHK_CMD) begin
            wr_idx = CNT_W'(DATA_W + 1);
        end else if (rx_cnt == CNT_W'(DATA_W)) begin
            wr_idx = CNT_W'(DATA_W);
        end else if (MSB_FIRST) begin
            wr_idx = rx_cnt;
        end else begin
            wr_idx = CNT_W'(DATA_W - 1) - rx_cnt;
        end
    end

    // Per-bit update of the receive word: cleared at frame start, one bit
    // written per capture edge, otherwise held.
    for (genvar gi = 0; gi < FRAME_W; gi++) begin : g_rx_bit
        assign rx_data_next[gi] = rx_load ? 1'b0 :
                                  (cap_en && (wr_idx == CNT_W'(gi))) ? MOSI :
                                  rx_data[gi];
    end

    // Next-state and control decode; SS_n high aborts any in-progress frame.
    always_comb begin
        state_next     = state_reg;
        rx_load        = 1'b0;
        cap_en         = 1'b0;
        rx_dec         = 1'b0;
        tx_load        = 1'b0;
        tx_dec         = 1'b0;
        rd_set         = 1'b0;
        rd_clr         = 1'b0;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        done_next      = 1'b0;
        miso_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!SS_n) begin
                    state_next = CHK_CMD;
                    rx_load    = 1'b1;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end else begin
                    cap_en = 1'b1;
                    if (!cmd_is_read(MOSI)) begin
                        state_next = WRITE;
                    end else if (rd_addr_seen_reg) begin
                        state_next = READ_DATA;
                    end else begin
                        state_next = READ_ADD;
                    end
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end else begin
                    cap_en = 1'b1;
                    rx_dec = 1'b1;
                    if (rx_zero) begin
                        rx_valid_next = 1'b1;
                        if (state_reg == READ_DATA) begin
                            state_next = TX_WAIT;
                        end else begin
                            state_next = HOLD;
                            rd_set     = (state_reg == READ_ADD);
                        end
                    end
                end
            end
            TX_WAIT: begin
                if (SS_n) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                    rd_clr         = 1'b1;
                end else if (tx_valid) begin
                    tx_load    = 1'b1;
                    miso_next  = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
                    state_next = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (SS_n) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                    rd_clr         = 1'b1;
                end else if (tx_zero) begin
                    rd_clr     = 1'b1;
                    state_next = HOLD;
                end else begin
                    miso_next = tx_shift_w[0];
                    tx_dec    = 1'b1;
                end
            end
            HOLD: begin
                if (SS_n) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and the read-address-seen flag that picks READ_DATA.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= IDLE;
            rd_addr_seen_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (rd_set) begin
                rd_addr_seen_reg <= 1'b1;
            end else if (rd_clr) begin
                rd_addr_seen_reg <= 1'b0;
            end
        end
    end

    // Registered outputs: strobes, MISO and the receive word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            done      <= 1'b0;
            MISO      <= 1'b0;
            rx_data   <= '0;
        end else begin
            rx_valid  <= rx_valid_next;
            frame_err <= frame_err_next;
            done      <= done_next;
            MISO      <= miso_next;
            rx_data   <= rx_data_next;
        end
    end

    // Read word is latched once when the RAM data is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_buf_reg <= '0;
        end else if (tx_load) begin
            tx_buf_reg <= tx_data;
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: two instances (8-bit MSB-first, 16-bit
// LSB-first) driven by directed and random frames. Expected output timelines
// are derived per frame from the protocol timing rules and compared per cycle.
module tb_spi_slave_param;
    import spi_slave_pkg::*;

    localparam int MAXC = 16384;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  ss_n = 2'b11;
    logic [1:0]  mosi = 2'b00;
    logic [1:0]  txv  = 2'b00;
    logic [7:0]  txd8 = '0;
    logic [15:0] txd16 = '0;
    logic [1:0]  miso, rxv, fe, dn;
    logic [9:0]  rxd8;
    logic [17:0] rxd16;

    int  cyc = 0;
    int  n_assert = 0;
    int  n_fail = 0;
    int  n_rxv_model = 0;
    int  n_rxv_dut = 0;
    int  last_t = 0;
    bit  chk_on = 1'b0;
    bit  rd_seen [2];

    bit          e_rxv     [2][MAXC];
    bit          e_ferr    [2][MAXC];
    bit          e_done    [2][MAXC];
    bit          e_miso    [2][MAXC];
    bit          e_rxd_chk [2][MAXC];
    logic [33:0] e_rxd     [2][MAXC];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut8 (
        .clk(clk), .rstn(rstn), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]),
        .rx_data(rxd8), .rx_valid(rxv[0]), .tx_data(txd8), .tx_valid(txv[0]),
        .frame_err(fe[0]), .done(dn[0])
    );

    spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b0)) u_dut16 (
        .clk(clk), .rstn(rstn), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]),
        .rx_data(rxd16), .rx_valid(rxv[1]), .tx_data(txd16), .tx_valid(txv[1]),
        .frame_err(fe[1]), .done(dn[1])
    );

    task automatic chk(input string nm, input int d, input logic [33:0] act, input logic [33:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %h, expected %h", nm, d, cyc, act, exp);
        end
    endtask

    function automatic logic [33:0] act_rxd(input int d);
        return (d == 0) ? 34'(rxd8) : 34'(rxd16);
    endfunction

    // Bit i of a frame on the wire: two command bits, then payload in the
    // instance's bit order.
    function automatic logic frame_bit(input int d, input logic [1:0] cmd, input logic [31:0] pay, input int i);
        int dw;
        dw = (d == 0) ? 8 : 16;
        if (i == 0) return cmd[1];
        if (i == 1) return cmd[0];
        return (d == 0) ? pay[dw-1-(i-2)] : pay[i-2];
    endfunction

    // Position in rx_data where wire bit i lands.
    function automatic int frame_pos(input int d, input int i);
        int dw;
        dw = (d == 0) ? 8 : 16;
        if (i == 0) return dw + 1;
        if (i == 1) return dw;
        return (d == 0) ? dw - 1 - (i - 2) : i - 2;
    endfunction

    function automatic logic tx_bit(input int d, input logic [31:0] tdat, input int k);
        return (d == 0) ? tdat[7-k] : tdat[k];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_txd(input int d, input logic [31:0] v);
        if (d == 0) txd8 = v[7:0];
        else        txd16 = v[15:0];
    endtask

    // Idle gap between frames, sometimes with a sub-cycle SS_n glitch.
    task automatic gap(input int d);
        txv[d] = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            #1 ss_n[d] = 1'b0;
            #2 ss_n[d] = 1'b1;
        end
        repeat ($urandom_range(0, 2)) step();
    endtask

    // Per-cycle comparison against the expected timelines.
    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            for (int d = 0; d < 2; d++) begin
                chk("rx_valid", d, 34'(rxv[d]), 34'(e_rxv[d][cyc]));
                chk("frame_err", d, 34'(fe[d]), 34'(e_ferr[d][cyc]));
                chk("done", d, 34'(dn[d]), 34'(e_done[d][cyc]));
                chk("miso", d, 34'(miso[d]), 34'(e_miso[d][cyc]));
                if (e_rxd_chk[d][cyc]) chk("rx_data", d, act_rxd(d), e_rxd[d][cyc]);
            end
            n_rxv_dut += int'(rxv[0]) + int'(rxv[1]);
        end
    end

    // One frame: abort_bits = wire bits sent before SS_n rises (-1 none);
    // txdly = idle cycles before tx_valid (-1 aborts in TX_WAIT);
    // tx_abort = SS_n sampled high at edge T+tx_abort (-1 none);
    // rst_m = reset asserted after edge T+rst_m (-1 none).
    task automatic run_frame(input int d, input logic [1:0] cmd, input logic [31:0] pay,
                             input int abort_bits, input int txdly, input logic [31:0] tdat,
                             input int tx_abort, input int hold, input int rst_m);
        int dw, e1, r, t, p;
        bit isrd;
        logic [33:0] full, part, mask;
        dw   = (d == 0) ? 8 : 16;
        isrd = cmd[1] && rd_seen[d];
        mask = (34'd1 << dw) - 34'd1;
        full = (34'(cmd) << dw) | (34'(pay) & mask);
        part = '0;
        $display("frame dut%0d cmd=%b pay=%h abort=%0d rd_data=%0d txdly=%0d tdat=%h txabort=%0d rst=%0d",
                 d, cmd, pay & 32'(mask), abort_bits, isrd, txdly, tdat & 32'(mask), tx_abort, rst_m);
        ss_n[d] = 1'b0;
        e1 = cyc + 1;
        for (int i = 0; i < dw + 2; i++) begin
            step();
            if (abort_bits == i) begin
                ss_n[d] = 1'b1;
                txv[d]  = 1'b0;
                p = e1 + 1 + i;
                e_ferr[d][p] = 1'b1;
                e_rxd_chk[d][p] = 1'b1;
                e_rxd[d][p] = part;
                step();
                gap(d);
                return;
            end
            mosi[d] = frame_bit(d, cmd, pay, i);
            part[frame_pos(d, i)] = mosi[d];
            txv[d] = 1'($urandom_range(0, 1));
            set_txd(d, $urandom);
        end
        r = e1 + dw + 2;
        e_rxv[d][r] = 1'b1;
        e_rxd_chk[d][r] = 1'b1;
        e_rxd[d][r] = full;
        n_rxv_model++;
        if (cmd[1] && !rd_seen[d]) rd_seen[d] = 1'b1;
        step();
        txv[d]  = 1'b0;
        mosi[d] = 1'($urandom_range(0, 1));
        if (isrd) begin
            if (txdly < 0) begin
                ss_n[d] = 1'b1;
                e_ferr[d][r+1] = 1'b1;
                rd_seen[d] = 1'b0;
                step();
                gap(d);
                return;
            end
            repeat (txdly) begin
                mosi[d] = 1'($urandom_range(0, 1));
                step();
            end
            t = cyc + 1;
            last_t = t;
            txv[d] = 1'b1;
            set_txd(d, tdat);
            for (int k = 0; k < dw; k++) begin
                if ((tx_abort < 0 || k < tx_abort) && (rst_m < 0 || k < rst_m))
                    e_miso[d][t+k] = tx_bit(d, tdat, k);
            end
            step();
            for (int m = 1; m <= dw; m++) begin
                txv[d] = 1'($urandom_range(0, 1));
                set_txd(d, $urandom);
                if (rst_m == m - 1) begin
                    #1 rstn = 1'b0;
                    #1;
                    chk("rst_miso", d, 34'(miso[d]), 34'd0);
                    chk("rst_rx_valid", d, 34'(rxv[d]), 34'd0);
                    chk("rst_frame_err", d, 34'(fe[d]), 34'd0);
                    chk("rst_done", d, 34'(dn[d]), 34'd0);
                    chk("rst_rx_data", d, act_rxd(d), 34'd0);
                    ss_n[d] = 1'b1;
                    txv[d]  = 1'b0;
                    rd_seen[0] = 1'b0;
                    rd_seen[1] = 1'b0;
                    step();
                    step();
                    rstn = 1'b1;
                    gap(d);
                    return;
                end
                if (tx_abort == m) begin
                    ss_n[d] = 1'b1;
                    txv[d]  = 1'b0;
                    e_ferr[d][t+m] = 1'b1;
                    e_rxd_chk[d][t+m] = 1'b1;
                    e_rxd[d][t+m] = full;
                    rd_seen[d] = 1'b0;
                    step();
                    gap(d);
                    return;
                end
                mosi[d] = 1'($urandom_range(0, 1));
                step();
            end
            rd_seen[d] = 1'b0;
        end
        repeat (hold) begin
            mosi[d] = 1'($urandom_range(0, 1));
            txv[d]  = 1'($urandom_range(0, 1));
            step();
        end
        ss_n[d] = 1'b1;
        txv[d]  = 1'b0;
        p = cyc + 1;
        e_done[d][p] = 1'b1;
        e_rxd_chk[d][p] = 1'b1;
        e_rxd[d][p] = full;
        step();
        gap(d);
    endtask

    initial begin
        logic [7:0] pat;
        int dw, ab, td, ta, nfr;
        logic [1:0] cmd;
        rd_seen[0] = 1'b0;
        rd_seen[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_miso", d, 34'(miso[d]), 34'd0);
            chk("reset_rx_valid", d, 34'(rxv[d]), 34'd0);
            chk("reset_rx_data", d, act_rxd(d), 34'd0);
            chk("reset_frame_err", d, 34'(fe[d]), 34'd0);
            chk("reset_done", d, 34'(dn[d]), 34'd0);
        end
        chk_on = 1'b1;
        step();

        // Write address 00_1010_0101 with tx_valid noise in WRITE/HOLD.
        run_frame(0, CMD_WR_ADDR, 32'hA5, -1, 0, 32'h0, -1, 2, -1);
        chk("tp_wr_addr", 0, act_rxd(0), 34'h0A5);

        // Read address, then read data answered with 8'hC3.
        run_frame(0, CMD_RD_ADDR, 32'h10, -1, 0, 32'h0, -1, 0, -1);
        chk("tp_rd_seen_set", 0, 34'(rd_seen[0]), 34'd1);
        run_frame(0, CMD_RD_DATA, 32'h5A, -1, 2, 32'hC3, -1, 1, -1);
        for (int k = 0; k < 8; k++) pat[7-k] = e_miso[0][last_t+k];
        chk("model_c3_pattern", 0, 34'(pat), 34'hC3);
        chk("tp_rd_seen_clr", 0, 34'(rd_seen[0]), 34'd0);
        // Leading-1 frame after readback must act as a read address.
        run_frame(0, CMD_RD_DATA, 32'h33, -1, 0, 32'h0, -1, 0, -1);

        // Write frame aborted after five captured bits.
        run_frame(0, CMD_WR_DATA, 32'hF0, 5, 0, 32'h0, -1, 0, -1);

        // 16-bit LSB-first write data 16'h1234.
        run_frame(1, CMD_WR_DATA, 32'h1234, -1, 0, 32'h0, -1, 1, -1);
        chk("tp_lsb_first", 1, act_rxd(1), 34'h11234);

        // Reset during TX_SHIFT (rd_addr_seen is set from the frame above).
        run_frame(0, CMD_RD_DATA, 32'h77, -1, 0, 32'hA6, -1, 0, 3);
        run_frame(0, CMD_RD_ADDR, 32'h01, -1, 0, 32'h0, -1, 0, -1);

        // Randomized frames on both instances.
        nfr = 0;
        while (nfr < 260 && cyc < MAXC - 200) begin
            int d;
            d   = (nfr % 3 == 2) ? 1 : 0;
            dw  = (d == 0) ? 8 : 16;
            cmd = 2'($urandom_range(0, 3));
            ab  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, dw + 1)) : -1;
            td  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
            ta  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, dw)) : -1;
            run_frame(d, cmd, $urandom, ab, td, $urandom, ta, int'($urandom_range(0, 3)), -1);
            nfr++;
        end

        step();
        step();
        chk("rx_valid_count", 0, 34'(n_rxv_dut), 34'(n_rxv_model));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
